// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe: pipelined alignment shifter for the FP datapath.
//
// One mux level per pipeline register: stage k applies shift bit k (a shift
// by 2^k) and registers the word together with its sideband (mode, fill,
// shift amount, lost-bit tracking). Valid/ready on both sides; in_ready is
// combinational from out_ready through the stage chain so bubbles collapse.
//
// Modes: 00 LSR, 01 ASR, 10 LSL, 11 ROR.
//
// Lost-bit tracking uses a zero-filled shadow copy of the operand, WIDTH+2
// bits wide: {operand, guard, round}. It shifts right alongside the real
// word. Bits falling off its bottom are ORed into sticky. Filled bits, which
// are never part of the operand, can therefore never reach sticky, guard or
// round. LSL/ROR load an all-zero shadow, so their flags stay 0.
//
// Optional feature macro: BARREL_SHIFT_GRS_EN
//   defined   -> out_guard/out_round ports exist; out_sticky covers only the
//                bits below the round position.
//   undefined -> out_sticky is the OR of every bit shifted out.

module barrel_shift_pipe #(
  parameter int WIDTH   = 16,
  parameter int SHIFT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic [1:0]         in_mode,
  input  logic               in_fill,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
`ifdef BARREL_SHIFT_GRS_EN
  output logic               out_guard,
  output logic               out_round,
`endif
  output logic               out_sticky
);

  localparam int VW = WIDTH + 2;

  localparam logic [1:0] MODE_LSR = 2'b00;
  localparam logic [1:0] MODE_ASR = 2'b01;
  localparam logic [1:0] MODE_LSL = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  // Pipeline registers, one entry per stage
  logic [SHIFT_W-1:0] valid_r;
  logic [WIDTH-1:0]   data_r   [SHIFT_W];
  logic [VW-1:0]      shadow_r [SHIFT_W];
  logic [SHIFT_W-1:0] sticky_r;
  logic [1:0]         mode_r   [SHIFT_W];
  logic [SHIFT_W-1:0] fill_r;
  logic [SHIFT_W-1:0] shift_r  [SHIFT_W];

  // Stage inputs (from ports for stage 0, previous register otherwise)
  logic [SHIFT_W-1:0] stg_valid_s;
  logic [WIDTH-1:0]   stg_data_s   [SHIFT_W];
  logic [VW-1:0]      stg_shadow_s [SHIFT_W];
  logic [SHIFT_W-1:0] stg_sticky_s;
  logic [1:0]         stg_mode_s   [SHIFT_W];
  logic [SHIFT_W-1:0] stg_fill_s;
  logic [SHIFT_W-1:0] stg_shift_s  [SHIFT_W];

  // Stage results, captured by the stage register when it loads
  logic [WIDTH-1:0]   nx_data_s   [SHIFT_W];
  logic [VW-1:0]      nx_shadow_s [SHIFT_W];
  logic [SHIFT_W-1:0] nx_sticky_s;

  logic [SHIFT_W-1:0] load_s;

  // Shift one word by a fixed amount in the requested mode.
  function automatic logic [WIDTH-1:0] shift_word(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       m,
    input logic             f,
    input int unsigned      amt
  );
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] fv;
    logic [WIDTH-1:0] res;
    int unsigned      rot;
    ones = '1;
    fv   = {WIDTH{f}};
    rot  = amt % WIDTH;
    case (m)
      MODE_LSR: res = (d >> amt) | (fv & ~(ones >> amt));
      MODE_ASR: res = (d >> amt) | ({WIDTH{d[WIDTH-1]}} & ~(ones >> amt));
      MODE_LSL: res = (d << amt) | (fv & ~(ones << amt));
      MODE_ROR: res = (d >> rot) | (d << (WIDTH - rot));
      default:  res = d;
    endcase
    return res;
  endfunction

  // OR of the shadow bits that fall off the bottom in a right shift by amt.
  function automatic logic shadow_lost(
    input logic [VW-1:0] v,
    input int unsigned   amt
  );
    logic [VW-1:0] ones;
    ones = '1;
    return |(v & ~(ones << amt));
  endfunction

  // Route ports into stage 0 and each register into the following stage.
  always_comb begin
    stg_valid_s     = '0;
    stg_sticky_s    = '0;
    stg_fill_s      = '0;
    stg_valid_s[0]  = in_valid;
    stg_data_s[0]   = in_data;
    stg_mode_s[0]   = in_mode;
    stg_fill_s[0]   = in_fill;
    stg_shift_s[0]  = in_shift;
    stg_sticky_s[0] = 1'b0;
    case (in_mode)
      MODE_LSR, MODE_ASR: stg_shadow_s[0] = {in_data, 2'b00};
      default:            stg_shadow_s[0] = '0;
    endcase
    for (int k = 1; k < SHIFT_W; k++) begin
      stg_valid_s[k]  = valid_r[k-1];
      stg_data_s[k]   = data_r[k-1];
      stg_shadow_s[k] = shadow_r[k-1];
      stg_sticky_s[k] = sticky_r[k-1];
      stg_mode_s[k]   = mode_r[k-1];
      stg_fill_s[k]   = fill_r[k-1];
      stg_shift_s[k]  = shift_r[k-1];
    end
  end

  // Per-stage mux level: shift by 2^k when shift bit k is set.
  always_comb begin
    nx_sticky_s = '0;
    for (int k = 0; k < SHIFT_W; k++) begin
      if (stg_shift_s[k][k]) begin
        nx_data_s[k]   = shift_word(stg_data_s[k], stg_mode_s[k], stg_fill_s[k],
                                    32'd1 << k);
        nx_shadow_s[k] = stg_shadow_s[k] >> (32'd1 << k);
        nx_sticky_s[k] = stg_sticky_s[k] | shadow_lost(stg_shadow_s[k], 32'd1 << k);
      end else begin
        nx_data_s[k]   = stg_data_s[k];
        nx_shadow_s[k] = stg_shadow_s[k];
        nx_sticky_s[k] = stg_sticky_s[k];
      end
    end
`ifndef BARREL_SHIFT_GRS_EN
    // Without separate guard/round outputs those two bits are also lost.
    nx_sticky_s[SHIFT_W-1] = nx_sticky_s[SHIFT_W-1]
                           | nx_shadow_s[SHIFT_W-1][1]
                           | nx_shadow_s[SHIFT_W-1][0];
`endif
  end

  // Load enables: a stage loads when it, or any stage after it, is empty,
  // or when the output is being drained.
  always_comb begin : load_chain
    logic acc;
    acc    = out_ready;
    load_s = '0;
    for (int k = SHIFT_W - 1; k >= 0; k--) begin
      acc       = acc | ~valid_r[k];
      load_s[k] = acc;
    end
  end

  assign in_ready = load_s[0];

  // Stage registers: async clear, capture on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r  <= '0;
      sticky_r <= '0;
      fill_r   <= '0;
      for (int k = 0; k < SHIFT_W; k++) begin
        data_r[k]   <= '0;
        shadow_r[k] <= '0;
        mode_r[k]   <= 2'b00;
        shift_r[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < SHIFT_W; k++) begin
        if (load_s[k]) begin
          valid_r[k] <= stg_valid_s[k];
          if (stg_valid_s[k]) begin
            data_r[k]   <= nx_data_s[k];
            shadow_r[k] <= nx_shadow_s[k];
            sticky_r[k] <= nx_sticky_s[k];
            mode_r[k]   <= stg_mode_s[k];
            fill_r[k]   <= stg_fill_s[k];
            shift_r[k]  <= stg_shift_s[k];
          end
        end
      end
    end
  end

  assign out_valid  = valid_r[SHIFT_W-1];
  assign out_data   = data_r[SHIFT_W-1];
  assign out_sticky = sticky_r[SHIFT_W-1];
`ifdef BARREL_SHIFT_GRS_EN
  assign out_guard  = shadow_r[SHIFT_W-1][1];
  assign out_round  = shadow_r[SHIFT_W-1][0];
`endif

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Directed bench for barrel_shift_pipe: a 16/4 instance and a 24/5 instance.
module tb_barrel_shift_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // 16-bit / 4-stage instance
  logic        a_in_valid = 1'b0, a_in_ready, a_in_fill = 1'b0;
  logic [15:0] a_in_data = 16'h0000, a_out_data;
  logic [3:0]  a_in_shift = 4'd0;
  logic [1:0]  a_in_mode = 2'b00;
  logic        a_out_valid, a_out_ready = 1'b1, a_out_sticky;
  logic        a_out_guard, a_out_round;

  // 24-bit / 5-stage instance
  logic        b_in_valid = 1'b0, b_in_ready, b_in_fill = 1'b0;
  logic [23:0] b_in_data = 24'h000000, b_out_data;
  logic [4:0]  b_in_shift = 5'd0;
  logic [1:0]  b_in_mode = 2'b00;
  logic        b_out_valid, b_out_ready = 1'b1, b_out_sticky;
  logic        b_out_guard, b_out_round;

`ifndef BARREL_SHIFT_GRS_EN
  assign a_out_guard = 1'b0;
  assign a_out_round = 1'b0;
  assign b_out_guard = 1'b0;
  assign b_out_round = 1'b0;
`endif

  barrel_shift_pipe #(.WIDTH(16), .SHIFT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_shift(a_in_shift), .in_mode(a_in_mode), .in_fill(a_in_fill),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
`ifdef BARREL_SHIFT_GRS_EN
    .out_guard(a_out_guard), .out_round(a_out_round),
`endif
    .out_sticky(a_out_sticky)
  );

  barrel_shift_pipe #(.WIDTH(24), .SHIFT_W(5)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_shift(b_in_shift), .in_mode(b_in_mode), .in_fill(b_in_fill),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
`ifdef BARREL_SHIFT_GRS_EN
    .out_guard(b_out_guard), .out_round(b_out_round),
`endif
    .out_sticky(b_out_sticky)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One word through the 16-bit pipe; entered at posedge+1 with the pipe empty.
  task automatic run_a(input string tag, input logic [15:0] d, input logic [3:0] s,
                       input logic [1:0] m, input logic f, input logic [15:0] exp_d,
                       input logic exp_st, input logic exp_g, input logic exp_r,
                       input logic exp_st_grs);
    int cyc;
    a_in_valid = 1'b1; a_in_data = d; a_in_shift = s; a_in_mode = m; a_in_fill = f;
    a_out_ready = 1'b1;
    #1 chk({tag, "_in_ready"}, a_in_ready, 1);
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_in_data = ~d; a_in_shift = ~s; a_in_mode = ~m; a_in_fill = ~f;
    cyc = 1;
    while (!a_out_valid && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_latency"}, cyc, 4);
    chk({tag, "_data"}, a_out_data, exp_d);
`ifdef BARREL_SHIFT_GRS_EN
    chk({tag, "_sticky"}, a_out_sticky, exp_st_grs);
    chk({tag, "_guard"}, a_out_guard, exp_g);
    chk({tag, "_round"}, a_out_round, exp_r);
`else
    chk({tag, "_sticky"}, a_out_sticky, exp_st);
`endif
    @(posedge clk); #1;
    chk({tag, "_drained"}, a_out_valid, 0);
  endtask

  // One word through the 24-bit pipe; same calling convention as run_a.
  task automatic run_b(input string tag, input logic [23:0] d, input logic [4:0] s,
                       input logic [1:0] m, input logic f, input logic [23:0] exp_d,
                       input logic exp_st, input logic exp_g, input logic exp_r,
                       input logic exp_st_grs);
    int cyc;
    b_in_valid = 1'b1; b_in_data = d; b_in_shift = s; b_in_mode = m; b_in_fill = f;
    b_out_ready = 1'b1;
    #1 chk({tag, "_in_ready"}, b_in_ready, 1);
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_in_data = ~d; b_in_shift = ~s; b_in_mode = ~m; b_in_fill = ~f;
    cyc = 1;
    while (!b_out_valid && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_latency"}, cyc, 5);
    chk({tag, "_data"}, b_out_data, exp_d);
`ifdef BARREL_SHIFT_GRS_EN
    chk({tag, "_sticky"}, b_out_sticky, exp_st_grs);
    chk({tag, "_guard"}, b_out_guard, exp_g);
    chk({tag, "_round"}, b_out_round, exp_r);
`else
    chk({tag, "_sticky"}, b_out_sticky, exp_st);
`endif
    @(posedge clk); #1;
    chk({tag, "_drained"}, b_out_valid, 0);
  endtask

  logic [15:0] s_data [8] = '{16'h0001, 16'h0012, 16'h0123, 16'h1234,
                              16'h2345, 16'h3456, 16'h4567, 16'hABCD};
  logic [15:0] s_exp  [8] = '{16'h0010, 16'h0120, 16'h1230, 16'h2340,
                              16'h3450, 16'h4560, 16'h5670, 16'hBCD0};

  initial begin
    int sent, got, stall, last_t, wait_cyc;
    logic [15:0] held;
    bit stalled_prev;

    // Asynchronous reset, checked before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", a_out_data, 16'h0000);
    chk("rst_out_sticky", a_out_sticky, 0);
    chk("rst_b_out_valid", b_out_valid, 0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", a_in_ready, 1);

    // Single words through the 16-bit pipe
    //     tag       data      sh    mode   fill  exp       st    g     r     st_grs
    run_a("lsr_b400", 16'hB400, 4'd3,  2'b00, 1'b0, 16'h1680, 1'b0, 1'b0, 1'b0, 1'b0);
    run_a("asr_8005", 16'h8005, 4'd2,  2'b01, 1'b0, 16'hE001, 1'b1, 1'b0, 1'b1, 1'b0);
    run_a("ror_1234", 16'h1234, 4'd4,  2'b11, 1'b0, 16'h4123, 1'b0, 1'b0, 1'b0, 1'b0);
    run_a("lsl_1234", 16'h1234, 4'd4,  2'b10, 1'b1, 16'h234F, 1'b0, 1'b0, 1'b0, 1'b0);
    run_a("lsr_zero", 16'hFFFF, 4'd0,  2'b00, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    run_a("lsr_fill", 16'h00FF, 4'd4,  2'b00, 1'b1, 16'hF00F, 1'b1, 1'b1, 1'b1, 1'b1);
    run_a("lsr_max",  16'h1234, 4'd15, 2'b00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    run_a("asr_pos",  16'h7FF0, 4'd5,  2'b01, 1'b0, 16'h03FF, 1'b1, 1'b1, 1'b0, 1'b0);
    run_a("ror_15",   16'h8001, 4'd15, 2'b11, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
    run_a("asr_neg",  16'hFFFF, 4'd15, 2'b01, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b1);

    // Stream of 8 words (LSL by 4), 5-cycle output stall after 2 results
    a_in_shift = 4'd4; a_in_mode = 2'b10; a_in_fill = 1'b0;
    sent = 0; got = 0; stall = 0; last_t = -1; stalled_prev = 1'b0; held = 16'h0000;
    for (int t = 0; t < 40 && got < 8; t++) begin
      if (got == 2 && stall < 5) begin
        a_out_ready = 1'b0;
        stall++;
      end else begin
        a_out_ready = 1'b1;
      end
      a_in_valid = (sent < 8);
      a_in_data  = s_data[(sent < 8) ? sent : 0];
      #1;
      chk("stream_in_ready", a_in_ready, (a_out_ready || (sent - got) < 4) ? 1 : 0);
      if (a_out_valid && !a_out_ready) begin
        if (stalled_prev) chk("stream_hold", a_out_data, held);
        held = a_out_data;
        stalled_prev = 1'b1;
      end else begin
        stalled_prev = 1'b0;
      end
      if (a_out_valid && a_out_ready) begin
        chk("stream_data", a_out_data, s_exp[got]);
        got++;
        last_t = t;
      end
      if (a_in_valid && a_in_ready) sent++;
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    chk("stream_count", got, 8);
    chk("stream_last_cycle", last_t, 16);
    @(posedge clk); #1;
    chk("stream_no_extra", a_out_valid, 0);

    // Reset with three words in flight
    a_out_ready = 1'b0; a_in_mode = 2'b00; a_in_shift = 4'd1;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 16'h1000 + 16'(i);
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    wait_cyc = 0;
    while (!a_out_valid && wait_cyc < 10) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    chk("midrst_pre_valid", a_out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_async_valid", a_out_valid, 0);
    chk("midrst_async_data", a_out_data, 16'h0000);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("midrst_no_output", a_out_valid, 0);
      @(posedge clk); #1;
    end
    run_a("post_rst", 16'h00FF, 4'd4, 2'b00, 1'b1, 16'hF00F, 1'b1, 1'b1, 1'b1, 1'b1);

    // 24-bit / 5-stage instance: shift amounts reaching or exceeding WIDTH
    run_b("b_lsr_27", 24'h000001, 5'd27, 2'b00, 1'b1, 24'hFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    run_b("b_ror_25", 24'h000001, 5'd25, 2'b11, 1'b0, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_b("b_asr_30", 24'h800000, 5'd30, 2'b01, 1'b0, 24'hFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    run_b("b_lsl_24", 24'h000001, 5'd24, 2'b10, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
